// File: rtl/bcd_operand_loader.sv
// bcd_operand_loader: operand entry stage for the one-digit BCD adder path.
// A debounced or plain-synchronised active-low key loads operand A on the
// first press, then operand B plus carry-in on the second press. The set is
// offered downstream with valid/ready and held for the adder and displays.
// Optional input debouncing is compiled in with the macro
// BCD_LOADER_DEBOUNCE_EN.
//
// Handshake: out_valid_o rises when B is loaded and stays high, with a_o,
// b_o and cin_o constant, until a rising clock edge sees out_valid_o and
// out_ready_i both high; that edge completes the transfer and returns the
// FSM to GET_A. out_ready_i is ignored whenever out_valid_o is low.

module bcd_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit_i,
    input  logic       cin_i,
    input  logic       key_n_i,
    input  logic       abort_i,
    input  logic       out_ready_i,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       cin_o,
    output logic       out_valid_o,
    output logic       err_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        HOLD  = 2'b10
    } state_t;

    // Fewer than two stable cycles makes the debouncer meaningless; this
    // empty block just names the illegal configuration in elaboration output.
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_cycles_too_small
    end

    logic   s1_q, s2_q;
    logic   lvl;
    logic   lvl_d_q;
    logic   press;
    state_t state_q;
    logic [3:0] a_q, b_q;
    logic   cin_q, valid_q, err_q;

    // Two-flop synchroniser for the asynchronous key; idle (released) is 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= key_n_i;
            s2_q <= s1_q;
        end
    end

`ifdef BCD_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          deb_lvl_q;
    logic [CW-1:0] cnt_q;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_lvl_q <= 1'b1;
            cnt_q     <= '0;
        end else if (s2_q != deb_lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_lvl_q <= s2_q;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign lvl = deb_lvl_q;
`else
    assign lvl = s2_q;
`endif

    // Delayed level for falling-edge detection; a held key gives one press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lvl_d_q <= 1'b1;
        end else begin
            lvl_d_q <= lvl;
        end
    end

    assign press = lvl_d_q & ~lvl;

    // Operand-entry FSM with registered outputs; abort outranks everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= GET_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort_i) begin
            state_q <= GET_A;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (press) begin
                        if (digit_i <= 4'd9) begin
                            a_q     <= digit_i;
                            err_q   <= 1'b0;
                            state_q <= GET_B;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GET_B: begin
                    if (press) begin
                        if (digit_i <= 4'd9) begin
                            b_q     <= digit_i;
                            cin_q   <= cin_i;
                            err_q   <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Presses are dropped here; operands persist after the
                    // transfer so the displays keep showing them.
                    if (valid_q && out_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= GET_A;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= GET_A;
                end
            endcase
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign cin_o       = cin_q;
    assign out_valid_o = valid_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: doc/bcd_operand_loader.md
Name: bcd_operand_loader

Overview:
- Upstream stage of the one-digit BCD adder/display path.
- Takes one 4-bit digit from the switches and a raw active-low pushbutton.
- Loads operand A on the first press, then operand B and carry-in on the second press.
- Presents {A, B, cin} to the adder stage with a valid/ready handshake, and holds the values stable for the adder and HEX displays.
- Rejects non-BCD digits (>9) with an error flag.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change. Used only when the debounce feature is compiled in. Board builds override it to ~1_000_000. Must be >=2.

Ports:
- Clock, in, 1: system clock; all state updates on the rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- digit_in, in, 4: operand digit from the switches; sampled only on an accepted press.
- cin_in, in, 1: carry-in switch; sampled together with operand B.
- key_n, in, 1: raw pushbutton, active-low, asynchronous to Clock.
- abort, in, 1: synchronous clear back to GET_A.
- out_ready, in, 1: consumer accepts the operand set.
- a_out, out, 4: latched operand A.
- b_out, out, 4: latched operand B.
- cin_out, out, 1: latched carry-in.
- out_valid, out, 1: operand set complete and held.
- err, out, 1: last press carried a non-BCD digit.
- state_out, out, 2: FSM state for LED display. GET_A=2'b00, GET_B=2'b01, HOLD=2'b10.

Behaviour:
- Reset (async, active-high):
  - a_out=0, b_out=0, cin_out=0, out_valid=0, err=0, state=GET_A.
  - Synchroniser flops and debounced level reset to 1 (released); debounce counter resets to 0.
- Input path:
  - key_n passes through a 2-flop synchroniser (s1, s2).
  - The level lvl is s2 without debounce, or the debounced level with debounce.
  - Register lvl_d <= lvl. press = lvl_d & ~lvl, a one-cycle pulse on each falling edge only.
  - Release generates nothing. A held button yields exactly one press.
- FSM acts on press at the next rising edge:
  - GET_A, press:
    - digit_in<=9: a_out<=digit_in, err<=0, go to GET_B.
    - digit_in>9: err<=1, a_out unchanged, stay in GET_A.
  - GET_B, press:
    - digit_in<=9: b_out<=digit_in, cin_out<=cin_in, err<=0, out_valid<=1, go to HOLD.
    - digit_in>9: err<=1, stay in GET_B.
  - HOLD:
    - out_valid=1, and a_out, b_out, cin_out are held constant.
    - Presses are ignored (no latch, err unchanged).
    - On out_valid & out_ready at an edge: out_valid<=0, go to GET_A.
    - a_out, b_out, cin_out keep their last values so the displays persist until overwritten.
  - Encoding 2'b11 is unreachable; if entered, the next edge goes to GET_A with out_valid<=0.
- abort:
  - At the next edge: state<=GET_A, out_valid<=0, err<=0. Operand registers are unchanged.
  - abort has priority over press and over the handshake in the same cycle.
- Simultaneous events:
  - A press in the same cycle as a HOLD handshake is dropped; state goes to GET_A only.
  - A press coincident with Reset assertion is lost.
  - Reset mid-sequence discards a partially loaded A (a_out returns to 0).
- Latency (no debounce): key_n falls before edge k; s1 at k, s2 at k+1, press high during cycle after k+1; a_out/b_out update at edge k+2.
- out_ready is don't-care outside HOLD.

Optional Feature:
- Macro: BCD_LOADER_DEBOUNCE_EN.
- Defined:
  - A counter (width clog2(DEBOUNCE_CYCLES)+1) increments while s2 != deb_lvl and clears to 0 whenever s2 == deb_lvl.
  - When the count reaches DEBOUNCE_CYCLES-1 with s2 still differing, deb_lvl<=s2 and the counter clears.
  - lvl=deb_lvl. Added latency is DEBOUNCE_CYCLES edges.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- Undefined: lvl=s2, no counter logic, and every synchronised falling edge is a press.

Test Plan:
- Reset, then digit_in=4'd7 press, digit_in=4'd5 with cin_in=1 press, out_ready=0 -> a_out=7, b_out=5, cin_out=1, out_valid=1, state_out=2'b10, held for 20 cycles.
- From HOLD, pulse out_ready=1 for one cycle -> out_valid=0 and state_out=2'b00 on the next edge; a_out=7 and b_out=5 are retained.
- In GET_A, press with digit_in=4'd12 -> err=1, state_out=2'b00, a_out unchanged. Then press with digit_in=4'd3 -> err=0, a_out=3, state_out=2'b01.
- key_n held low for 50 cycles -> exactly one press, A loaded once. Press in HOLD with digit_in=4'd9 -> b_out unchanged, out_valid stays 1.
- After loading A=2, assert Reset asynchronously mid-cycle -> all outputs 0 immediately. Separately, abort in HOLD together with out_ready -> GET_A, err=0, out_valid=0.
- With BCD_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: 10-cycle low glitch -> no press; 20-cycle low -> one press with a_out updating DEBOUNCE_CYCLES edges later than the non-debounce build.
